// File: rtl/dual_issue_ctrl.sv
// Dual-issue controller feeding the ID/REG pipeline register: holds one decoded pair,
// resolves structural/intra-pair/scoreboard hazards and tracks in-flight writer latency.
module dual_issue_ctrl #(
    parameter int NUM_REGS = 128,
    parameter int EVEN_LAT = 6,
    parameter int ODD_LAT  = 4,
    parameter int OPC_W    = 11
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             stall_in,
    input  logic             flush,
    input  logic             pipe_IN1,
    input  logic             pipe_IN2,
    input  logic [2:0]       srcUsed_IN1,
    input  logic [2:0]       srcUsed_IN2,
    input  logic             regWriteEnable_IN1,
    input  logic             regWriteEnable_IN2,
    input  logic             source_IN1,
    input  logic             source_IN2,
    input  logic [OPC_W-1:0] opcode_IN1,
    input  logic [OPC_W-1:0] opcode_IN2,
    input  logic [6:0]       readRegisterRA_IN1,
    input  logic [6:0]       readRegisterRA_IN2,
    input  logic [6:0]       readRegisterRB_IN1,
    input  logic [6:0]       readRegisterRB_IN2,
    input  logic [6:0]       readRegisterRC_IN1,
    input  logic [6:0]       readRegisterRC_IN2,
    input  logic [6:0]       readRegisterRT_IN1,
    input  logic [6:0]       readRegisterRT_IN2,
    input  logic [6:0]       immediate7BIT_IN1,
    input  logic [6:0]       immediate7BIT_IN2,
    input  logic [9:0]       immediate10BIT_IN1,
    input  logic [9:0]       immediate10BIT_IN2,
    input  logic [15:0]      immediate16BIT_IN1,
    input  logic [15:0]      immediate16BIT_IN2,
    input  logic [17:0]      immediate18BIT_IN1,
    input  logic [17:0]      immediate18BIT_IN2,
    output logic             valid_ID1,
    output logic             valid_ID2,
    output logic             pipe_ID1,
    output logic             pipe_ID2,
    output logic [2:0]       srcUsed_ID1,
    output logic [2:0]       srcUsed_ID2,
    output logic             regWriteEnable_ID1,
    output logic             regWriteEnable_ID2,
    output logic             source_ID1,
    output logic             source_ID2,
    output logic [OPC_W-1:0] opcode_ID1,
    output logic [OPC_W-1:0] opcode_ID2,
    output logic [6:0]       readRegisterRA_ID1,
    output logic [6:0]       readRegisterRA_ID2,
    output logic [6:0]       readRegisterRB_ID1,
    output logic [6:0]       readRegisterRB_ID2,
    output logic [6:0]       readRegisterRC_ID1,
    output logic [6:0]       readRegisterRC_ID2,
    output logic [6:0]       readRegisterRT_ID1,
    output logic [6:0]       readRegisterRT_ID2,
    output logic [6:0]       immediate7BIT_ID1,
    output logic [6:0]       immediate7BIT_ID2,
    output logic [9:0]       immediate10BIT_ID1,
    output logic [9:0]       immediate10BIT_ID2,
    output logic [15:0]      immediate16BIT_ID1,
    output logic [15:0]      immediate16BIT_ID2,
    output logic [17:0]      immediate18BIT_ID1,
    output logic [17:0]      immediate18BIT_ID2
);

    localparam int MAX_LAT = (EVEN_LAT > ODD_LAT) ? EVEN_LAT : ODD_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);
    localparam logic [CNT_W-1:0] EVEN_CNT = CNT_W'(EVEN_LAT);
    localparam logic [CNT_W-1:0] ODD_CNT  = CNT_W'(ODD_LAT);

    typedef struct packed {
        logic             pipe;
        logic [2:0]       src_used;   // {rc, rb, ra}
        logic             we;
        logic             source;
        logic [OPC_W-1:0] opcode;
        logic [6:0]       ra;
        logic [6:0]       rb;
        logic [6:0]       rc;
        logic [6:0]       rt;
        logic [6:0]       imm7;
        logic [9:0]       imm10;
        logic [15:0]      imm16;
        logic [17:0]      imm18;
    } instr_t;

    typedef enum logic [1:0] {EMPTY, PAIR, SPLIT} state_t;

    state_t           state;
    instr_t           hold1_p0, hold2_p0;
    instr_t           in1, in2, slot1, slot2;
    logic [CNT_W-1:0] sb_cnt [NUM_REGS];
    logic             vld_p1_1, vld_p1_2;
    logic             iss1, iss2, iss_s, last_issue, accept;

    function automatic logic busy(input logic [CNT_W-1:0] c);
        return c != '0;
    endfunction

    // Intra-pair dependency: I2 reads or rewrites the register I1 is writing.
    function automatic logic pair_dep(input instr_t a, input instr_t b);
        return a.we && ((b.src_used[0] && b.ra == a.rt) ||
                        (b.src_used[1] && b.rb == a.rt) ||
                        (b.src_used[2] && b.rc == a.rt) ||
                        (b.we && b.rt == a.rt));
    endfunction

    function automatic logic [CNT_W-1:0] lat_of(input logic pipe);
        return pipe ? ODD_CNT : EVEN_CNT;
    endfunction

    always_comb begin
        in1 = '{pipe_IN1, srcUsed_IN1, regWriteEnable_IN1, source_IN1, opcode_IN1,
                readRegisterRA_IN1, readRegisterRB_IN1, readRegisterRC_IN1, readRegisterRT_IN1,
                immediate7BIT_IN1, immediate10BIT_IN1, immediate16BIT_IN1, immediate18BIT_IN1};
        in2 = '{pipe_IN2, srcUsed_IN2, regWriteEnable_IN2, source_IN2, opcode_IN2,
                readRegisterRA_IN2, readRegisterRB_IN2, readRegisterRC_IN2, readRegisterRT_IN2,
                immediate7BIT_IN2, immediate10BIT_IN2, immediate16BIT_IN2, immediate18BIT_IN2};
    end

    // Issue decision from held pair and scoreboard
    logic hz1, hz2, go;
    always_comb begin
        hz1 = (hold1_p0.src_used[0] && busy(sb_cnt[hold1_p0.ra])) ||
              (hold1_p0.src_used[1] && busy(sb_cnt[hold1_p0.rb])) ||
              (hold1_p0.src_used[2] && busy(sb_cnt[hold1_p0.rc])) ||
              (hold1_p0.we && busy(sb_cnt[hold1_p0.rt]));
        hz2 = (hold2_p0.src_used[0] && busy(sb_cnt[hold2_p0.ra])) ||
              (hold2_p0.src_used[1] && busy(sb_cnt[hold2_p0.rb])) ||
              (hold2_p0.src_used[2] && busy(sb_cnt[hold2_p0.rc])) ||
              (hold2_p0.we && busy(sb_cnt[hold2_p0.rt]));
        go    = !stall_in && !flush;
        iss1  = (state == PAIR) && go && !hz1;
        iss2  = iss1 && !hz2 && (hold1_p0.pipe != hold2_p0.pipe) && !pair_dep(hold1_p0, hold2_p0);
        iss_s = (state == SPLIT) && go && !hz2;
        slot1    = '0;
        slot2    = '0;
        vld_p1_1 = 1'b0;
        vld_p1_2 = 1'b0;
        if (iss1) begin
            slot1    = hold1_p0;
            vld_p1_1 = 1'b1;
        end else if (iss_s) begin
            slot1    = hold2_p0;
            vld_p1_1 = 1'b1;
        end
        if (iss2) begin
            slot2    = hold2_p0;
            vld_p1_2 = 1'b1;
        end
        last_issue = iss2 || iss_s;
        in_ready   = !flush && ((state == EMPTY) || last_issue);
        accept     = in_valid && in_ready;
    end

    // Control state and scoreboard
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= EMPTY;
            for (int r = 0; r < NUM_REGS; r++) sb_cnt[r] <= '0;
        end else begin
            if (flush)                 state <= EMPTY;
            else if (accept)           state <= PAIR;
            else if (iss1 && !iss2)    state <= SPLIT;
            else if (last_issue)       state <= EMPTY;
            for (int r = 0; r < NUM_REGS; r++) begin
                if (vld_p1_1 && slot1.we && slot1.rt == 7'(r))
                    sb_cnt[r] <= lat_of(slot1.pipe);
                else if (vld_p1_2 && slot2.we && slot2.rt == 7'(r))
                    sb_cnt[r] <= lat_of(slot2.pipe);
                else if (sb_cnt[r] != '0)
                    sb_cnt[r] <= sb_cnt[r] - 1'b1;
            end
        end
    end

    // Held pair capture
    always_ff @(posedge clk) begin
        if (accept && !reset) begin
            hold1_p0 <= in1;
            hold2_p0 <= in2;
        end
    end

    assign valid_ID1          = vld_p1_1;
    assign valid_ID2          = vld_p1_2;
    assign pipe_ID1           = slot1.pipe;
    assign pipe_ID2           = slot2.pipe;
    assign srcUsed_ID1        = slot1.src_used;
    assign srcUsed_ID2        = slot2.src_used;
    assign regWriteEnable_ID1 = slot1.we;
    assign regWriteEnable_ID2 = slot2.we;
    assign source_ID1         = slot1.source;
    assign source_ID2         = slot2.source;
    assign opcode_ID1         = slot1.opcode;
    assign opcode_ID2         = slot2.opcode;
    assign readRegisterRA_ID1 = slot1.ra;
    assign readRegisterRA_ID2 = slot2.ra;
    assign readRegisterRB_ID1 = slot1.rb;
    assign readRegisterRB_ID2 = slot2.rb;
    assign readRegisterRC_ID1 = slot1.rc;
    assign readRegisterRC_ID2 = slot2.rc;
    assign readRegisterRT_ID1 = slot1.rt;
    assign readRegisterRT_ID2 = slot2.rt;
    assign immediate7BIT_ID1  = slot1.imm7;
    assign immediate7BIT_ID2  = slot2.imm7;
    assign immediate10BIT_ID1 = slot1.imm10;
    assign immediate10BIT_ID2 = slot2.imm10;
    assign immediate16BIT_ID1 = slot1.imm16;
    assign immediate16BIT_ID2 = slot2.imm16;
    assign immediate18BIT_ID1 = slot1.imm18;
    assign immediate18BIT_ID2 = slot2.imm18;

endmodule

// File: tb/tb_dual_issue_ctrl.sv
// Bench for dual_issue_ctrl: table of instruction pairs with queued per-cycle expectations,
// plus hand-written flush, stall, flush+stall and mid-run reset sequences.
module tb_dual_issue_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, in_valid, in_ready, stall_in, flush;
    logic pipe_IN1, pipe_IN2, regWriteEnable_IN1, regWriteEnable_IN2, source_IN1, source_IN2;
    logic [2:0] srcUsed_IN1, srcUsed_IN2;
    logic [10:0] opcode_IN1, opcode_IN2;
    logic [6:0] readRegisterRA_IN1, readRegisterRA_IN2, readRegisterRB_IN1, readRegisterRB_IN2;
    logic [6:0] readRegisterRC_IN1, readRegisterRC_IN2, readRegisterRT_IN1, readRegisterRT_IN2;
    logic [6:0] immediate7BIT_IN1, immediate7BIT_IN2;
    logic [9:0] immediate10BIT_IN1, immediate10BIT_IN2;
    logic [15:0] immediate16BIT_IN1, immediate16BIT_IN2;
    logic [17:0] immediate18BIT_IN1, immediate18BIT_IN2;
    logic valid_ID1, valid_ID2, pipe_ID1, pipe_ID2, regWriteEnable_ID1, regWriteEnable_ID2;
    logic source_ID1, source_ID2;
    logic [2:0] srcUsed_ID1, srcUsed_ID2;
    logic [10:0] opcode_ID1, opcode_ID2;
    logic [6:0] readRegisterRA_ID1, readRegisterRA_ID2, readRegisterRB_ID1, readRegisterRB_ID2;
    logic [6:0] readRegisterRC_ID1, readRegisterRC_ID2, readRegisterRT_ID1, readRegisterRT_ID2;
    logic [6:0] immediate7BIT_ID1, immediate7BIT_ID2;
    logic [9:0] immediate10BIT_ID1, immediate10BIT_ID2;
    logic [15:0] immediate16BIT_ID1, immediate16BIT_ID2;
    logic [17:0] immediate18BIT_ID1, immediate18BIT_ID2;

    dual_issue_ctrl #(.NUM_REGS(128), .EVEN_LAT(6), .ODD_LAT(4), .OPC_W(11)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .stall_in(stall_in), .flush(flush),
        .pipe_IN1(pipe_IN1), .pipe_IN2(pipe_IN2),
        .srcUsed_IN1(srcUsed_IN1), .srcUsed_IN2(srcUsed_IN2),
        .regWriteEnable_IN1(regWriteEnable_IN1), .regWriteEnable_IN2(regWriteEnable_IN2),
        .source_IN1(source_IN1), .source_IN2(source_IN2),
        .opcode_IN1(opcode_IN1), .opcode_IN2(opcode_IN2),
        .readRegisterRA_IN1(readRegisterRA_IN1), .readRegisterRA_IN2(readRegisterRA_IN2),
        .readRegisterRB_IN1(readRegisterRB_IN1), .readRegisterRB_IN2(readRegisterRB_IN2),
        .readRegisterRC_IN1(readRegisterRC_IN1), .readRegisterRC_IN2(readRegisterRC_IN2),
        .readRegisterRT_IN1(readRegisterRT_IN1), .readRegisterRT_IN2(readRegisterRT_IN2),
        .immediate7BIT_IN1(immediate7BIT_IN1), .immediate7BIT_IN2(immediate7BIT_IN2),
        .immediate10BIT_IN1(immediate10BIT_IN1), .immediate10BIT_IN2(immediate10BIT_IN2),
        .immediate16BIT_IN1(immediate16BIT_IN1), .immediate16BIT_IN2(immediate16BIT_IN2),
        .immediate18BIT_IN1(immediate18BIT_IN1), .immediate18BIT_IN2(immediate18BIT_IN2),
        .valid_ID1(valid_ID1), .valid_ID2(valid_ID2),
        .pipe_ID1(pipe_ID1), .pipe_ID2(pipe_ID2),
        .srcUsed_ID1(srcUsed_ID1), .srcUsed_ID2(srcUsed_ID2),
        .regWriteEnable_ID1(regWriteEnable_ID1), .regWriteEnable_ID2(regWriteEnable_ID2),
        .source_ID1(source_ID1), .source_ID2(source_ID2),
        .opcode_ID1(opcode_ID1), .opcode_ID2(opcode_ID2),
        .readRegisterRA_ID1(readRegisterRA_ID1), .readRegisterRA_ID2(readRegisterRA_ID2),
        .readRegisterRB_ID1(readRegisterRB_ID1), .readRegisterRB_ID2(readRegisterRB_ID2),
        .readRegisterRC_ID1(readRegisterRC_ID1), .readRegisterRC_ID2(readRegisterRC_ID2),
        .readRegisterRT_ID1(readRegisterRT_ID1), .readRegisterRT_ID2(readRegisterRT_ID2),
        .immediate7BIT_ID1(immediate7BIT_ID1), .immediate7BIT_ID2(immediate7BIT_ID2),
        .immediate10BIT_ID1(immediate10BIT_ID1), .immediate10BIT_ID2(immediate10BIT_ID2),
        .immediate16BIT_ID1(immediate16BIT_ID1), .immediate16BIT_ID2(immediate16BIT_ID2),
        .immediate18BIT_ID1(immediate18BIT_ID1), .immediate18BIT_ID2(immediate18BIT_ID2)
    );

    typedef struct packed {
        logic        pipe;
        logic [2:0]  src;
        logic        we;
        logic [6:0]  ra, rb, rc, rt;
        logic [10:0] opc;
    } ins_t;

    typedef struct packed {
        ins_t  i1, i2;
        logic  both;
        logic [3:0] wait_n;
    } vec_t;

    typedef struct packed {
        logic        v1;
        logic [10:0] op1;
        logic [6:0]  rt1;
        logic        v2;
        logic [10:0] op2;
        logic [6:0]  rt2;
        logic        rdy;
    } exp_t;

    exp_t q[$];
    vec_t vecs[8];
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic ins_t mk(input logic pipe, input logic [2:0] src, input logic we,
                                input logic [6:0] ra, input logic [6:0] rb, input logic [6:0] rc,
                                input logic [6:0] rt, input logic [10:0] opc);
        ins_t i;
        i = '{pipe, src, we, ra, rb, rc, rt, opc};
        return i;
    endfunction

    task automatic drive(input ins_t a, input ins_t b);
        pipe_IN1 = a.pipe;  srcUsed_IN1 = a.src;  regWriteEnable_IN1 = a.we;  source_IN1 = a.opc[0];
        opcode_IN1 = a.opc; readRegisterRA_IN1 = a.ra; readRegisterRB_IN1 = a.rb;
        readRegisterRC_IN1 = a.rc; readRegisterRT_IN1 = a.rt;
        immediate7BIT_IN1 = a.opc[6:0]; immediate10BIT_IN1 = a.opc[9:0];
        immediate16BIT_IN1 = 16'(a.opc) + 16'd100; immediate18BIT_IN1 = 18'(a.opc) + 18'd200;
        pipe_IN2 = b.pipe;  srcUsed_IN2 = b.src;  regWriteEnable_IN2 = b.we;  source_IN2 = b.opc[0];
        opcode_IN2 = b.opc; readRegisterRA_IN2 = b.ra; readRegisterRB_IN2 = b.rb;
        readRegisterRC_IN2 = b.rc; readRegisterRT_IN2 = b.rt;
        immediate7BIT_IN2 = b.opc[6:0]; immediate10BIT_IN2 = b.opc[9:0];
        immediate16BIT_IN2 = 16'(b.opc) + 16'd100; immediate18BIT_IN2 = 18'(b.opc) + 18'd200;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    function automatic int nonzero_counts();
        int n = 0;
        for (int r = 0; r < 128; r++) if (dut.sb_cnt[r] != 0) n++;
        return n;
    endfunction

    task automatic run_vec(input vec_t v, input int idx);
        exp_t e;
        exp_t act;
        int k = 0;
        idle(8);
        drive(v.i1, v.i2);
        in_valid = 1'b1;
        if (v.both) begin
            q.push_back('{1'b1, v.i1.opc, v.i1.rt, 1'b1, v.i2.opc, v.i2.rt, 1'b1});
        end else begin
            q.push_back('{1'b1, v.i1.opc, v.i1.rt, 1'b0, 11'd0, 7'd0, 1'b0});
            for (int w = 0; w < int'(v.wait_n); w++) q.push_back('0);
            q.push_back('{1'b1, v.i2.opc, v.i2.rt, 1'b0, 11'd0, 7'd0, 1'b1});
        end
        q.push_back('{1'b0, 11'd0, 7'd0, 1'b0, 11'd0, 7'd0, 1'b1});
        @(negedge clk);
        in_valid = 1'b0;
        while (q.size() > 0) begin
            e = q.pop_front();
            #1;
            act = '{valid_ID1, opcode_ID1, readRegisterRT_ID1,
                    valid_ID2, opcode_ID2, readRegisterRT_ID2, in_ready};
            check($sformatf("vec%0d_cyc%0d", idx, k), 64'(act), 64'(e));
            k++;
            if (q.size() > 0) @(negedge clk);
        end
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; stall_in = 1'b0; flush = 1'b0;
        drive('0, '0);

        // pipe, src{rc,rb,ra}, we, ra, rb, rc, rt, opcode
        vecs[0] = '{mk(0, 3'b000, 1, 1, 2, 3, 3, 11'h101), mk(1, 3'b000, 1, 1, 2, 3, 4, 11'h102), 1'b1, 4'd0};
        vecs[1] = '{mk(0, 3'b000, 1, 0, 0, 0, 5, 11'h111), mk(1, 3'b001, 0, 5, 0, 0, 6, 11'h112), 1'b0, 4'd6};
        vecs[2] = '{mk(0, 3'b000, 1, 0, 0, 0, 11, 11'h121), mk(0, 3'b000, 1, 0, 0, 0, 12, 11'h122), 1'b0, 4'd0};
        vecs[3] = '{mk(1, 3'b000, 1, 0, 0, 0, 10, 11'h131), mk(0, 3'b000, 1, 0, 0, 0, 10, 11'h132), 1'b0, 4'd4};
        vecs[4] = '{mk(0, 3'b000, 0, 0, 0, 0, 5, 11'h141), mk(1, 3'b001, 1, 5, 0, 0, 6, 11'h142), 1'b1, 4'd0};
        vecs[5] = '{mk(1, 3'b000, 1, 9, 9, 9, 0, 11'h151), mk(0, 3'b100, 0, 1, 1, 0, 8, 11'h152), 1'b0, 4'd4};
        vecs[6] = '{mk(0, 3'b000, 1, 0, 0, 0, 20, 11'h161), mk(1, 3'b001, 0, 21, 20, 0, 22, 11'h162), 1'b1, 4'd0};
        vecs[7] = '{mk(1, 3'b000, 1, 0, 0, 0, 1, 11'h171), mk(1, 3'b000, 1, 0, 0, 0, 2, 11'h172), 1'b0, 4'd0};

        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        check("reset_in_ready", 64'(in_ready), 64'd1);
        check("reset_valids", 64'({valid_ID1, valid_ID2}), 64'd0);
        check("reset_counts", 64'(nonzero_counts()), 64'd0);

        for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

        // scoreboard load on a dual issue, plus full field transfer on slot 2
        idle(8);
        drive(mk(0, 3'b000, 1, 0, 0, 0, 3, 11'h0B1), mk(1, 3'b000, 1, 0, 0, 0, 4, 11'h0B2));
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("cnt_both_valid", 64'({valid_ID1, valid_ID2, in_ready}), 64'b111);
        check("cnt_imm16_id2", 64'(immediate16BIT_ID2), 64'(16'h0B2 + 16'd100));
        check("cnt_imm18_id1", 64'(immediate18BIT_ID1), 64'(18'h0B1 + 18'd200));
        check("cnt_pipe_src", 64'({pipe_ID1, pipe_ID2, source_ID1, source_ID2}), 64'b0110);
        @(posedge clk);
        #1;
        check("cnt_r3", 64'(dut.sb_cnt[3]), 64'd6);
        check("cnt_r4", 64'(dut.sb_cnt[4]), 64'd4);
        @(negedge clk);

        // flush while SPLIT, with a pair offered in the same cycle
        idle(8);
        drive(mk(0, 3'b000, 1, 0, 0, 0, 7, 11'h0C1), mk(1, 3'b001, 0, 7, 0, 0, 8, 11'h0C2));
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        check("flush_pre_cnt7", 64'(dut.sb_cnt[7]), 64'd3);
        check("flush_pre_held", 64'(valid_ID1), 64'd0);
        drive(mk(0, 3'b000, 0, 0, 0, 0, 50, 11'h0C3), mk(1, 3'b000, 0, 0, 0, 0, 51, 11'h0C4));
        flush = 1'b1;
        in_valid = 1'b1;
        #1;
        check("flush_in_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        flush = 1'b0;
        in_valid = 1'b0;
        #1;
        check("flush_post", 64'({valid_ID1, valid_ID2, in_ready}), 64'b001);
        check("flush_cnt7", 64'(dut.sb_cnt[7]), 64'd2);
        @(negedge clk);
        #1;
        check("flush_no_accept", 64'({valid_ID1, valid_ID2}), 64'd0);

        // three stall cycles over a hazard-free pair
        idle(8);
        drive(mk(0, 3'b000, 1, 0, 0, 0, 30, 11'h0D1), mk(1, 3'b000, 1, 0, 0, 0, 31, 11'h0D2));
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        stall_in = 1'b1;
        for (int s = 0; s < 3; s++) begin
            #1;
            check($sformatf("stall_cyc%0d", s), 64'({valid_ID1, valid_ID2, in_ready}), 64'd0);
            @(negedge clk);
        end
        stall_in = 1'b0;
        #1;
        check("stall_release", 64'({valid_ID1, opcode_ID1, valid_ID2, opcode_ID2, in_ready}),
              64'({1'b1, 11'h0D1, 1'b1, 11'h0D2, 1'b1}));

        // flush and stall together: flush wins
        @(negedge clk);
        drive(mk(0, 3'b000, 1, 0, 0, 0, 40, 11'h0E1), mk(1, 3'b000, 1, 0, 0, 0, 41, 11'h0E2));
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        stall_in = 1'b1;
        flush = 1'b1;
        #1;
        check("fs_during", 64'({valid_ID1, valid_ID2, in_ready}), 64'd0);
        @(negedge clk);
        stall_in = 1'b0;
        flush = 1'b0;
        #1;
        check("fs_after", 64'({valid_ID1, valid_ID2, in_ready}), 64'b001);

        // reset in SPLIT with an in-flight writer
        idle(8);
        drive(mk(0, 3'b000, 1, 0, 0, 0, 9, 11'h0F1), mk(1, 3'b001, 0, 9, 0, 0, 10, 11'h0F2));
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_pre_cnt9", 64'(dut.sb_cnt[9]), 64'd5);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_counts", 64'(nonzero_counts()), 64'd0);
        check("rst_post", 64'({valid_ID1, valid_ID2, in_ready}), 64'b001);
        @(negedge clk);
        #1;
        check("rst_pair_gone", 64'({valid_ID1, valid_ID2}), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
